// File: rtl/mem_instrucciones_sinc.sv
// Byte-addressed instruction memory with a byte-wide programming port and a
// fetch request/response handshake of configurable latency and error flags.
module mem_instrucciones_sinc #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned DATA_W      = 32,
    parameter bit          BIG_ENDIAN  = 1'b1,
    parameter int unsigned LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              instr_valid,
    input  logic              instr_ack,
    output logic [DATA_W-1:0] instr,
    output logic [1:0]        instr_err
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // Storage is not touched by reset; contents start at zero only.
    logic [7:0] mem_q [DEPTH_BYTES] = '{default: 8'h00};

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cap_word_q, cap_word_d;
    logic [1:0]        cap_err_q, cap_err_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [1:0]        err_q, err_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] fetch_word;
    logic              fetch_oor;
    logic              fetch_mis;
    logic [ADDR_W:0]   sum;
    logic [7:0]        byte_v;
    logic              accept;

    always_ff @(posedge clk) begin
        if (prog_we && (32'(prog_addr) < DEPTH_BYTES)) begin
            mem_q[prog_addr[IDX_W-1:0]] <= prog_data;
        end
    end

    // Bytes are read from the array as it stands before the edge, so a
    // simultaneous programming write is not seen by the fetch being accepted.
    always_comb begin
        fetch_word = '0;
        fetch_oor  = 1'b0;
        sum        = '0;
        byte_v     = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            sum    = {1'b0, fetch_addr} + (ADDR_W+1)'(k);
            byte_v = '0;
            if (32'(sum[ADDR_W-1:0]) < DEPTH_BYTES) begin
                byte_v = mem_q[sum[IDX_W-1:0]];
            end else begin
                fetch_oor = 1'b1;
            end
            if (sum[ADDR_W]) begin
                fetch_oor = 1'b1;
            end
            if (BIG_ENDIAN) begin
                fetch_word[DATA_W-1-8*k -: 8] = byte_v;
            end else begin
                fetch_word[8*k +: 8] = byte_v;
            end
        end
        fetch_mis = (32'(fetch_addr) % NB) != 0;
    end

    assign fetch_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && instr_ack);
    assign accept      = fetch_req && fetch_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_word_d = cap_word_q;
        cap_err_d  = cap_err_q;
        instr_d    = instr_q;
        err_d      = err_q;
        valid_d    = valid_q;
        if (accept) begin
            cap_word_d = fetch_word;
            cap_err_d  = {fetch_oor, fetch_mis};
        end
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        instr_d = fetch_word;
                        err_d   = {fetch_oor, fetch_mis};
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 2'(LATENCY - 2);
                        valid_d = 1'b0;
                    end
                end else if ((state_q == S_RESP) && instr_ack) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    instr_d = cap_word_q;
                    err_d   = cap_err_q;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cap_word_q <= '0;
            cap_err_q  <= '0;
            instr_q    <= '0;
            err_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_word_q <= cap_word_d;
            cap_err_q  <= cap_err_d;
            instr_q    <= instr_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_err   = err_q;

endmodule

// File: tb/tb_mem_instrucciones_sinc.sv
// Directed bench: big/little-endian LATENCY=1 instances share stimulus; a
// 64-byte LATENCY=3 instance covers range, latency, hold and reset cases.
module tb_mem_instrucciones_sinc;

    logic        clk;
    logic        rst_n;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [7:0]  prog_data;
    logic        req_a, ack_a;
    logic [7:0]  addr_a;
    logic        req_b, ack_b;
    logic [7:0]  addr_b;
    logic        rdy0, v0, rdy1, v1, rdy2, v2;
    logic [31:0] instr0, instr1, instr2;
    logic [1:0]  err0, err1, err2;

    int n_tests = 0;
    int n_fail  = 0;

    mem_instrucciones_sinc #(.ADDR_W(8), .DEPTH_BYTES(256), .DATA_W(32), .BIG_ENDIAN(1'b1), .LATENCY(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .fetch_req(req_a), .fetch_addr(addr_a), .fetch_ready(rdy0), .instr_valid(v0),
        .instr_ack(ack_a), .instr(instr0), .instr_err(err0));

    mem_instrucciones_sinc #(.ADDR_W(8), .DEPTH_BYTES(64), .DATA_W(32), .BIG_ENDIAN(1'b1), .LATENCY(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .fetch_req(req_b), .fetch_addr(addr_b), .fetch_ready(rdy1), .instr_valid(v1),
        .instr_ack(ack_b), .instr(instr1), .instr_err(err1));

    mem_instrucciones_sinc #(.ADDR_W(8), .DEPTH_BYTES(256), .DATA_W(32), .BIG_ENDIAN(1'b0), .LATENCY(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .fetch_req(req_a), .fetch_addr(addr_a), .fetch_ready(rdy2), .instr_valid(v2),
        .instr_ack(ack_a), .instr(instr2), .instr_err(err2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [7:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic fetch_a(input logic [7:0] a);
        req_a = 1'b1; addr_a = a;
        step();
        req_a = 1'b0;
    endtask

    task automatic ack_a_once();
        ack_a = 1'b1;
        step();
        ack_a = 1'b0;
    endtask

    task automatic fetch_b(input logic [7:0] a);
        req_b = 1'b1; addr_b = a;
        step();
        req_b = 1'b0;
        step();
        step();
    endtask

    task automatic ack_b_once();
        ack_b = 1'b1;
        step();
        ack_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        req_a = 1'b0; ack_a = 1'b0; addr_a = '0;
        req_b = 1'b0; ack_b = 1'b0; addr_b = '0;
        step(); step();
        chk("rst_valid0", 32'(v0), 32'd0);
        chk("rst_instr0", instr0, 32'h0);
        chk("rst_err0",   32'(err0), 32'd0);
        chk("rst_ready0", 32'(rdy0), 32'd1);
        chk("rst_valid1", 32'(v1), 32'd0);
        rst_n = 1'b1;
        step();

        prog(8'h00, 8'h20); prog(8'h01, 8'h10); prog(8'h02, 8'h00); prog(8'h03, 8'h01);
        prog(8'h04, 8'h8C); prog(8'h05, 8'h11); prog(8'h06, 8'h00); prog(8'h07, 8'h04);
        prog(8'h08, 8'h12); prog(8'h09, 8'h34); prog(8'h0A, 8'h56); prog(8'h0B, 8'h78);
        prog(8'hFE, 8'hAA); prog(8'hFF, 8'hBB); prog(8'h3E, 8'h3C); prog(8'h3F, 8'h01);

        // Aligned fetch, both byte orders
        fetch_a(8'h00);
        chk("f0_valid", 32'(v0), 32'd1);
        chk("f0_be",    instr0, 32'h20100001);
        chk("f0_le",    instr2, 32'h01001020);
        chk("f0_err",   32'(err0), 32'd0);
        chk("f0_ready_held", 32'(rdy0), 32'd0);
        ack_a_once();
        chk("f0_idle_valid", 32'(v0), 32'd0);

        // Misaligned fetch
        fetch_a(8'h02);
        chk("f2_be",  instr0, 32'h00018C11);
        chk("f2_le",  instr2, 32'h118C0100);
        chk("f2_err", 32'(err0), 32'd1);
        ack_a_once();

        // Back-to-back fetches with ack held high
        req_a = 1'b1; ack_a = 1'b1; addr_a = 8'h00;
        step();
        chk("b2b0_valid", 32'(v0), 32'd1);
        chk("b2b0_instr", instr0, 32'h20100001);
        addr_a = 8'h04;
        step();
        chk("b2b1_valid", 32'(v0), 32'd1);
        chk("b2b1_instr", instr0, 32'h8C110004);
        addr_a = 8'h08;
        step();
        chk("b2b2_valid", 32'(v0), 32'd1);
        chk("b2b2_instr", instr0, 32'h12345678);
        req_a = 1'b0;
        step();
        chk("b2b_end_valid", 32'(v0), 32'd0);
        chk("b2b_end_instr", instr0, 32'h12345678);
        ack_a = 1'b0;

        // Wrapping fetch at top of address space
        fetch_a(8'hFE);
        chk("wrap_be",  instr0, 32'hAABB2010);
        chk("wrap_le",  instr2, 32'h1020BBAA);
        chk("wrap_err", 32'(err0), 32'd3);
        ack_a_once();

        // Programming write on the acceptance edge is not seen
        prog_we = 1'b1; prog_addr = 8'h01; prog_data = 8'hFF;
        fetch_a(8'h00);
        prog_we = 1'b0;
        chk("raw_old", instr0, 32'h20100001);
        ack_a_once();
        fetch_a(8'h00);
        chk("raw_new_be", instr0, 32'h20FF0001);
        chk("raw_new_le", instr2, 32'h0100FF20);
        ack_a_once();

        // LATENCY=3: valid first high after the second edge following acceptance
        req_b = 1'b1; addr_b = 8'h00;
        step();
        req_b = 1'b0;
        chk("lat_e0_valid", 32'(v1), 32'd0);
        chk("lat_e0_ready", 32'(rdy1), 32'd0);
        step();
        chk("lat_e1_valid", 32'(v1), 32'd0);
        step();
        chk("lat_e2_valid", 32'(v1), 32'd1);
        chk("lat_e2_instr", instr1, 32'h20FF0001);
        chk("lat_e2_err",   32'(err1), 32'd0);
        req_b = 1'b1; addr_b = 8'h04;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", 32'(v1), 32'd1);
            chk("hold_instr", instr1, 32'h20FF0001);
            chk("hold_ready", 32'(rdy1), 32'd0);
        end
        req_b = 1'b0; ack_b = 1'b1;
        #1;
        chk("ack_ready_comb", 32'(rdy1), 32'd1);
        step();
        ack_b = 1'b0;
        chk("ack_idle_valid", 32'(v1), 32'd0);
        chk("ack_idle_instr", instr1, 32'h20FF0001);
        step(); step(); step(); step();
        chk("ignored_req_valid", 32'(v1), 32'd0);

        // Reset while holding a response
        fetch_b(8'h00);
        chk("rresp_pre_valid", 32'(v1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rresp_valid", 32'(v1), 32'd0);
        chk("rresp_instr", instr1, 32'h0);
        chk("rresp_instr0", instr0, 32'h0);
        #1;
        rst_n = 1'b1;
        step(); step(); step(); step();
        chk("rresp_after_valid", 32'(v1), 32'd0);

        // Out-of-range tail on the 64-byte instance
        fetch_b(8'h3E);
        chk("oor62_instr", instr1, 32'h3C010000);
        chk("oor62_err",   32'(err1), 32'd3);
        ack_b_once();

        // Reset while waiting
        req_b = 1'b1; addr_b = 8'h00;
        step();
        req_b = 1'b0;
        chk("rwait_pre_valid", 32'(v1), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rwait_instr", instr1, 32'h0);
        chk("rwait_err",   32'(err1), 32'd0);
        chk("rwait_valid", 32'(v1), 32'd0);
        #1;
        rst_n = 1'b1;
        step(); step(); step(); step();
        chk("rwait_no_resp", 32'(v1), 32'd0);

        // Memory survives reset
        fetch_b(8'h00);
        chk("retain_valid", 32'(v1), 32'd1);
        chk("retain_instr", instr1, 32'h20FF0001);
        ack_b_once();
        fetch_b(8'h40);
        chk("oor64_instr", instr1, 32'h0);
        chk("oor64_err",   32'(err1), 32'd2);
        ack_b_once();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
